// File: rtl/rrp_burst_arbiter_pkg.sv
// Shared definitions for the round-robin burst arbiter: FSM state encoding and index-width helper.
package rrp_burst_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rrp_burst_arbiter_rr_select.sv
// Cyclic priority search: first set request bit strictly after last_i, wrapping to 0.
module rrp_burst_arbiter_rr_select #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned IDX_W = 3
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             hi_found;
    logic             lo_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Two ascending passes folded into one: indices above last win over the wrapped ones.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req_i[i]) begin
                if (IDX_W'(i) > last_i) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = IDX_W'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(i);
                end
            end
        end
        valid_o = hi_found | lo_found;
        idx_o   = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/rrp_burst_arbiter.sv
// Round-robin merger of N FWFT source FIFOs into one registered word stream,
// with enable mask, bounded bursts, hold preemption and saturating per-channel word counters.
module rrp_burst_arbiter
    import rrp_burst_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST      = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [WIDTH-1:0]              ENABLE,
    input  logic [WIDTH-1:0]              WRITE_REQ,
    input  logic [WIDTH-1:0]              HOLD_REQ,
    input  logic [WIDTH*DATA_WIDTH-1:0]   DATA_IN,
    output logic [WIDTH-1:0]              READ_GRANT,
    input  logic                          READY_IN,
    output logic                          WRITE_OUT,
    output logic [DATA_WIDTH-1:0]         DATA_OUT,
    output logic [idx_width(WIDTH)-1:0]   GRANT_IDX,
    output logic                          BUSY,
    input  logic                          CNT_CLR,
    output logic [WIDTH*CNT_WIDTH-1:0]    WORD_CNT
);

    localparam int unsigned IdxW = idx_width(WIDTH);
    localparam int unsigned BcW  = idx_width(BURST + 1);
    localparam logic [IdxW-1:0] LastRst = IdxW'(WIDTH - 1);

    state_e                state_q, state_d;
    logic [IdxW-1:0]       cur_q, cur_d;
    logic [IdxW-1:0]       last_q, last_d;
    logic [BcW-1:0]        burst_cnt_q, burst_cnt_d;
    logic                  write_out_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [CNT_WIDTH-1:0]  word_cnt_q [WIDTH];
    logic [CNT_WIDTH-1:0]  word_cnt_d [WIDTH];

    logic [WIDTH-1:0]      cand;
    logic                  sel_valid;
    logic [IdxW-1:0]       sel_idx;
    logic                  cur_req;
    logic                  cur_en;
    logic                  cur_hold;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  pop;
    logic                  burst_done;

    assign cand = WRITE_REQ & ENABLE;

    rrp_burst_arbiter_rr_select #(
        .WIDTH (WIDTH),
        .IDX_W (IdxW)
    ) u_rr_select (
        .req_i   (cand),
        .last_i  (last_q),
        .valid_o (sel_valid),
        .idx_o   (sel_idx)
    );

    assign cur_req  = WRITE_REQ[cur_q];
    assign cur_en   = ENABLE[cur_q];
    assign cur_hold = HOLD_REQ[cur_q];
    assign cur_data = DATA_IN[cur_q*DATA_WIDTH +: DATA_WIDTH];

    // The only pop source; gated by reset so a mid-burst reset loses no source word.
    assign pop = (state_q == StGrant) & READY_IN & cur_req & cur_en & ~RST;
    assign READ_GRANT = pop ? (WIDTH'(1) << cur_q) : '0;

    assign burst_done = (BURST != 0) && pop && ((32'(burst_cnt_q) + 32'd1) == BURST);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    cur_d       = sel_idx;
                    last_d      = sel_idx;
                    burst_cnt_d = '0;
                    state_d     = StGrant;
                end
            end
            StGrant: begin
                if (pop) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                // Hold keeps an empty or burst-exhausted channel, but never a disabled one.
                if (!cur_en || (!cur_hold && (!cur_req || burst_done))) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (CNT_CLR) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                word_cnt_d[i] = '0;
            end
        end else if (pop && (word_cnt_q[cur_q] != '1)) begin
            word_cnt_d[cur_q] = word_cnt_q[cur_q] + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            last_q      <= LastRst;
            burst_cnt_q <= '0;
            write_out_q <= 1'b0;
            data_out_q  <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                word_cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            write_out_q <= pop;
            if (pop) begin
                data_out_q <= cur_data;
            end
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign WRITE_OUT = write_out_q;
    assign DATA_OUT  = data_out_q;
    assign GRANT_IDX = cur_q;
    assign BUSY      = (state_q == StGrant);

    for (genvar g = 0; g < WIDTH; g++) begin : gen_word_cnt
        assign WORD_CNT[g*CNT_WIDTH +: CNT_WIDTH] = word_cnt_q[g];
    end

endmodule

// File: tb/tb_rrp_burst_arbiter.sv
// Bench: behavioural source FIFOs feed the arbiter; popped words go to a scoreboard queue
// that is matched against the registered output, and pop sequences are checked against tables.
module tb_rrp_burst_arbiter;

    localparam int unsigned N  = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam logic [8:0] RdyPat = 9'b111110011;

    typedef struct packed {
        logic [N-1:0] req;
        logic [N-1:0] en;
        logic [N-1:0] grant;
        logic [2:0]   idx;
        logic         busy;
    } vec_t;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    ENABLE;
    logic [N-1:0]    WRITE_REQ;
    logic [N-1:0]    HOLD_REQ;
    logic [N*DW-1:0] DATA_IN;
    logic [N-1:0]    READ_GRANT;
    logic            READY_IN;
    logic            WRITE_OUT;
    logic [DW-1:0]   DATA_OUT;
    logic [2:0]      GRANT_IDX;
    logic            BUSY;
    logic            CNT_CLR;
    logic [N*CW-1:0] WORD_CNT;

    rrp_burst_arbiter #(
        .WIDTH      (N),
        .DATA_WIDTH (DW),
        .BURST      (4),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENABLE     (ENABLE),
        .WRITE_REQ  (WRITE_REQ),
        .HOLD_REQ   (HOLD_REQ),
        .DATA_IN    (DATA_IN),
        .READ_GRANT (READ_GRANT),
        .READY_IN   (READY_IN),
        .WRITE_OUT  (WRITE_OUT),
        .DATA_OUT   (DATA_OUT),
        .GRANT_IDX  (GRANT_IDX),
        .BUSY       (BUSY),
        .CNT_CLR    (CNT_CLR),
        .WORD_CNT   (WORD_CNT)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] src_mem [N][64];
    int            rd_ptr  [N];
    int            wr_ptr  [N];
    int            seq;
    logic [DW-1:0] exp_q[$];
    int            pop_log[$];
    int            exp_log[$];
    int            checks;
    int            errors;
    vec_t          vecs [6];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_words(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            src_mem[ch][wr_ptr[ch]] = {4'hA, 4'(ch), 24'(seq)};
            seq++;
            wr_ptr[ch]++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rd_ptr[i] != wr_ptr[i]) begin
                WRITE_REQ[i]          = 1'b1;
                DATA_IN[i*DW +: DW]   = src_mem[i][rd_ptr[i]];
            end else begin
                WRITE_REQ[i]          = 1'b0;
                DATA_IN[i*DW +: DW]   = '0;
            end
        end
    endtask

    // One bus cycle: check the registered output against the scoreboard, record this
    // cycle's pop, then advance the source FIFOs after the edge.
    task automatic tick();
        logic [DW-1:0] w;
        logic [N-1:0]  g;
        int            ch;
        @(negedge CLK);
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("write_out", longint'(WRITE_OUT), 1);
            check("data_out", longint'(DATA_OUT), longint'(w));
        end else begin
            check("write_out_idle", longint'(WRITE_OUT), 0);
        end
        g  = READ_GRANT;
        ch = -1;
        check("grant_onehot", longint'($countones(g) <= 1), 1);
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                ch = i;
                if (rd_ptr[i] == wr_ptr[i]) begin
                    check("pop_nonempty", 0, 1);
                end else begin
                    exp_q.push_back(src_mem[i][rd_ptr[i]]);
                    rd_ptr[i]++;
                end
            end
        end
        pop_log.push_back(ch);
        @(posedge CLK);
        #1;
        drive();
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        ENABLE   = '1;
        HOLD_REQ = '0;
        READY_IN = 1'b1;
        CNT_CLR  = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd_ptr[i] = 0;
            wr_ptr[i] = 0;
        end
        drive();
        tick();
        tick();
        RST = 1'b0;
        pop_log.delete();
    endtask

    task automatic check_log(input string name);
        int act;
        for (int k = 0; k < exp_log.size(); k++) begin
            act = (k < pop_log.size()) ? pop_log[k] : -2;
            check($sformatf("%s[%0d]", name, k), longint'(act), longint'(exp_log[k]));
        end
    endtask

    initial begin
        int n0;
        int gl[$];
        checks = 0;
        errors = 0;
        seq    = 0;
        do_reset();

        // Reset state
        #1;
        check("rst_read_grant", longint'(READ_GRANT), 0);
        check("rst_write_out", longint'(WRITE_OUT), 0);
        check("rst_data_out", longint'(DATA_OUT), 0);
        check("rst_busy", longint'(BUSY), 0);
        check("rst_grant_idx", longint'(GRANT_IDX), 0);
        check("rst_word_cnt", longint'(WORD_CNT), 0);

        // First-grant table: grant one cycle after the request, cyclic search from last=5
        vecs[0] = '{req: 6'b100001, en: 6'b111111, grant: 6'b000001, idx: 3'd0, busy: 1'b1};
        vecs[1] = '{req: 6'b100000, en: 6'b111111, grant: 6'b100000, idx: 3'd5, busy: 1'b1};
        vecs[2] = '{req: 6'b111110, en: 6'b111100, grant: 6'b000100, idx: 3'd2, busy: 1'b1};
        vecs[3] = '{req: 6'b000000, en: 6'b111111, grant: 6'b000000, idx: 3'd0, busy: 1'b0};
        vecs[4] = '{req: 6'b100001, en: 6'b011110, grant: 6'b000000, idx: 3'd0, busy: 1'b0};
        vecs[5] = '{req: 6'b010010, en: 6'b111111, grant: 6'b000010, idx: 3'd1, busy: 1'b1};
        for (int v = 0; v < 6; v++) begin
            do_reset();
            ENABLE = vecs[v].en;
            for (int c = 0; c < N; c++) begin
                if (vecs[v].req[c]) push_words(c, 3);
            end
            drive();
            tick();
            #1;
            check($sformatf("vec%0d_grant", v), longint'(READ_GRANT), longint'(vecs[v].grant));
            check($sformatf("vec%0d_idx", v), longint'(GRANT_IDX), longint'(vecs[v].idx));
            check($sformatf("vec%0d_busy", v), longint'(BUSY), longint'(vecs[v].busy));
            tick();
            tick();
        end

        // Burst limit 4: ch1, idle, ch3, idle, ch1
        do_reset();
        push_words(1, 20);
        push_words(3, 20);
        drive();
        repeat (15) tick();
        exp_log = {-1, 1, 1, 1, 1, -1, 3, 3, 3, 3, -1, 1, 1, 1, 1};
        check_log("burst");
        check("burst_cnt1", longint'(WORD_CNT[1*CW +: CW]), 8);
        check("burst_cnt3", longint'(WORD_CNT[3*CW +: CW]), 4);

        // Hold on an emptied channel blocks ch2 until released
        do_reset();
        HOLD_REQ = 6'b000001;
        push_words(0, 2);
        push_words(2, 5);
        drive();
        repeat (8) tick();
        check("hold_busy", longint'(BUSY), 1);
        check("hold_idx", longint'(GRANT_IDX), 0);
        HOLD_REQ = '0;
        repeat (4) tick();
        exp_log = {-1, 0, 0, -1, -1, -1, -1, -1, -1, -1, 2, 2};
        check_log("hold");

        // Disable while holding releases the grant the next cycle
        do_reset();
        HOLD_REQ = 6'b000001;
        push_words(0, 1);
        push_words(2, 5);
        drive();
        repeat (4) tick();
        ENABLE = 6'b111110;
        check("hold_dis_busy_before", longint'(BUSY), 1);
        tick();
        check("hold_dis_busy_after", longint'(BUSY), 0);
        repeat (2) tick();
        exp_log = {-1, 0, -1, -1, -1, -1, 2};
        check_log("hold_dis");

        // Backpressure pattern 1,0,0,1 inside a burst
        do_reset();
        push_words(4, 10);
        drive();
        for (int k = 0; k < 9; k++) begin
            READY_IN = RdyPat[k];
            tick();
        end
        exp_log = {-1, 4, -1, -1, 4, 4, 4, -1, 4};
        check_log("bp");
        check("bp_cnt4", longint'(WORD_CNT[4*CW +: CW]), 5);

        // Disabled ch5 and wrap back to ch0
        do_reset();
        ENABLE = 6'b011111;
        for (int c = 0; c < N; c++) push_words(c, 8);
        drive();
        repeat (31) tick();
        gl.delete();
        for (int k = 0; k < pop_log.size(); k++) begin
            if (pop_log[k] != -1 && (k == 0 || pop_log[k-1] == -1)) gl.push_back(pop_log[k]);
        end
        pop_log = gl;
        exp_log = {0, 1, 2, 3, 4, 0};
        check_log("wrap");
        check("wrap_cnt5", longint'(WORD_CNT[5*CW +: CW]), 0);

        // Saturation at 15 with 20 pops
        do_reset();
        push_words(0, 20);
        drive();
        repeat (30) tick();
        n0 = 0;
        foreach (pop_log[k]) if (pop_log[k] == 0) n0++;
        check("sat_pops", longint'(n0), 20);
        check("sat_cnt0", longint'(WORD_CNT[0 +: CW]), 15);

        // Clear coincident with a pop wins
        do_reset();
        push_words(2, 10);
        drive();
        repeat (3) tick();
        check("clr_pre", longint'(WORD_CNT[2*CW +: CW]), 2);
        CNT_CLR = 1'b1;
        tick();
        CNT_CLR = 1'b0;
        check("clr_with_pop", longint'(WORD_CNT[2*CW +: CW]), 0);
        tick();
        check("clr_then_pop", longint'(WORD_CNT[2*CW +: CW]), 1);

        // Reset mid-burst
        do_reset();
        push_words(1, 10);
        drive();
        repeat (3) tick();
        RST = 1'b1;
        #1;
        check("rst_mid_gate", longint'(READ_GRANT), 0);
        tick();
        check("rst_mid_write_out", longint'(WRITE_OUT), 0);
        check("rst_mid_data_out", longint'(DATA_OUT), 0);
        check("rst_mid_busy", longint'(BUSY), 0);
        check("rst_mid_idx", longint'(GRANT_IDX), 0);
        check("rst_mid_cnt", longint'(WORD_CNT), 0);
        RST = 1'b0;
        tick();

        do_reset();
        check("scoreboard_drain", longint'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
